// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the MMU translation path and the external memory bus
// between the instruction-fetch (if) and load/store (ls) ports, and slots
// MMU reconfiguration from the CU in between accesses.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned PAGE_NUM_WIDTH = 20
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      if_req,
  input  logic [31:0]               if_vaddr,
  output logic                      if_ack,
  output logic [31:0]               if_rdata,
  output logic                      if_err,
  input  logic                      ls_req,
  input  logic                      ls_we,
  input  logic [3:0]                ls_be,
  input  logic [31:0]               ls_vaddr,
  input  logic [31:0]               ls_wdata,
  output logic                      ls_ack,
  output logic [31:0]               ls_rdata,
  output logic                      ls_err,
  input  logic                      cfg_req,
  input  logic                      cfg_en,
  input  logic [PAGE_NUM_WIDTH-1:0] cfg_vpage,
  input  logic [PAGE_NUM_WIDTH-1:0] cfg_ppage,
  output logic                      cfg_ack,
  output logic                      mmu_update_o,
  output logic                      mmu_en_o,
  output logic [PAGE_NUM_WIDTH-1:0] mmu_vpage_o,
  output logic [PAGE_NUM_WIDTH-1:0] mmu_ppage_o,
  output logic [31:0]               mmu_vaddr_o,
  input  logic [31:0]               mmu_paddr_i,
  input  logic                      mmu_error_i,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [3:0]                bus_be,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  input  logic                      bus_ready
);

  typedef enum logic [2:0] {IDLE, CFG, XLATE, BUS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        port_ls;      // granted port: 1 = ls, 0 = if
  logic        last_ls;      // port granted last: 1 = ls, 0 = if
  logic [31:0] vaddr_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] paddr_r;
  logic [7:0]  cnt;

  logic        grant;
  logic        grant_ls;
  logic        done_load;
  logic [31:0] done_rdata;
  logic        done_err;

  // State register
  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, arbitration and completion result
  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    grant_ls   = 1'b0;
    done_load  = 1'b0;
    done_rdata = '0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req) begin
          state_n = CFG;
        end else if (ls_req || if_req) begin
          grant    = 1'b1;
          // on a tie the port not granted last wins
          grant_ls = ls_req && (!if_req || !last_ls);
          state_n  = XLATE;
        end
      end
      CFG:   state_n = IDLE;
      XLATE: begin
        if (mmu_error_i) begin
          state_n   = DONE;
          done_load = 1'b1;
          done_err  = 1'b1;
        end else begin
          state_n = BUS;
        end
      end
      BUS: begin
        // ready beats timeout when both land in the same cycle
        if (bus_ready) begin
          state_n    = DONE;
          done_load  = 1'b1;
          done_rdata = we_r ? '0 : bus_rdata;
        end else if (cnt == CNT_LAST) begin
          state_n   = DONE;
          done_load = 1'b1;
          done_err  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, translation capture, timeout counter and port results
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      port_ls  <= 1'b0;
      last_ls  <= 1'b0;
      vaddr_r  <= '0;
      we_r     <= 1'b0;
      be_r     <= '0;
      wdata_r  <= '0;
      paddr_r  <= '0;
      cnt      <= '0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      ls_rdata <= '0;
      ls_err   <= 1'b0;
    end else begin
      if (grant) begin
        port_ls <= grant_ls;
        vaddr_r <= grant_ls ? ls_vaddr : if_vaddr;
        we_r    <= grant_ls & ls_we;
        be_r    <= grant_ls ? ls_be : 4'hF;
        wdata_r <= grant_ls ? ls_wdata : '0;
      end
      if (state == XLATE) begin
        paddr_r <= mmu_paddr_i;
        cnt     <= '0;
      end
      if (state == BUS) cnt <= cnt + 8'd1;
      if (done_load) begin
        if (port_ls) begin
          ls_rdata <= done_rdata;
          ls_err   <= done_err;
        end else begin
          if_rdata <= done_rdata;
          if_err   <= done_err;
        end
      end
      if (state == DONE) last_ls <= port_ls;
    end
  end

  // Outputs decoded from the state register; all zero in IDLE
  always_comb begin
    if_ack       = (state == DONE) && !port_ls;
    ls_ack       = (state == DONE) &&  port_ls;
    cfg_ack      = (state == CFG);
    mmu_update_o = (state == CFG);
    mmu_en_o     = (state == CFG) && cfg_en;
    mmu_vpage_o  = (state == CFG) ? cfg_vpage : '0;
    mmu_ppage_o  = (state == CFG) ? cfg_ppage : '0;
    mmu_vaddr_o  = (state == IDLE) ? '0 : vaddr_r;
    bus_req      = (state == BUS);
    bus_we       = (state == BUS) && we_r;
    bus_be       = (state == BUS) ? be_r : '0;
    bus_addr     = (state == BUS) ? paddr_r : '0;
    bus_wdata    = (state == BUS) ? wdata_r : '0;
  end

endmodule
